// File: rtl/wrr_arbiter_if.sv
// rtl/wrr_arbiter_if.sv - request/grant bundle between the sources and the weighted round-robin arbiter
interface wrr_arbiter_if #(
    parameter int CLIENTS  = 32,
    parameter int WEIGHT_W = 4
);
    localparam int IDX_W = $clog2(CLIENTS);

    logic [CLIENTS-1:0]          request;
    logic [CLIENTS*WEIGHT_W-1:0] weight;
    logic                        stall;
    logic                        lock;
    logic [CLIENTS-1:0]          grant;
    logic                        grant_valid;
    logic [IDX_W-1:0]            grant_id;

    modport master (
        output request, weight, stall, lock,
        input  grant, grant_valid, grant_id
    );

    modport slave (
        input  request, weight, stall, lock,
        output grant, grant_valid, grant_id
    );
endinterface

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with stall and single-cycle burst lock
module wrr_arbiter #(
    parameter int CLIENTS  = 32,
    parameter int WEIGHT_W = 4,
    localparam int IDX_W   = $clog2(CLIENTS)
) (
    input  logic          clock,
    input  logic          reset,
    wrr_arbiter_if.slave  bus
);
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [WEIGHT_W-1:0] cnt, cnt_nxt;
    logic                locked, locked_nxt;
    logic [IDX_W-1:0]    lock_id, lock_id_nxt;

    logic                search_hit;
    logic [IDX_W-1:0]    search_id;
    logic                lock_hit;
    logic                grant_any;
    logic [IDX_W-1:0]    sel;
    logic [WEIGHT_W-1:0] w_sel;
    logic [WEIGHT_W-1:0] ew;
    logic [WEIGHT_W:0]   used;

    // Circular priority search starting at ptr; first requester found wins.
    always_comb begin
        int idx;
        search_hit = 1'b0;
        search_id  = '0;
        idx        = 0;
        for (int k = 0; k < CLIENTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= CLIENTS) begin
                idx = idx - CLIENTS;
            end
            if (!search_hit && bus.request[IDX_W'(idx)]) begin
                search_hit = 1'b1;
                search_id  = IDX_W'(idx);
            end
        end
    end

    assign lock_hit  = locked && bus.request[lock_id];
    assign grant_any = !reset && !bus.stall && (|bus.request);
    assign sel       = lock_hit ? lock_id : search_id;
    assign w_sel     = bus.weight[int'(sel)*WEIGHT_W +: WEIGHT_W];
    assign ew        = (w_sel == '0) ? WEIGHT_W'(1) : w_sel;
    assign used      = (sel == ptr) ? ({1'b0, cnt} + 1'b1) : (WEIGHT_W+1)'(1);

    always_comb begin
        bus.grant       = '0;
        bus.grant_valid = 1'b0;
        bus.grant_id    = '0;
        if (grant_any) begin
            bus.grant[sel]  = 1'b1;
            bus.grant_valid = 1'b1;
            bus.grant_id    = sel;
        end
    end

    always_comb begin
        ptr_nxt     = ptr;
        cnt_nxt     = cnt;
        locked_nxt  = locked;
        lock_id_nxt = lock_id;
        if (grant_any) begin
            // A locked grant is a free extension: it neither advances ptr nor spends credit.
            if (!lock_hit) begin
                if (used >= {1'b0, ew}) begin
                    ptr_nxt = (sel == IDX_W'(CLIENTS-1)) ? '0 : sel + 1'b1;
                    cnt_nxt = '0;
                end else begin
                    ptr_nxt = sel;
                    cnt_nxt = used[WEIGHT_W-1:0];
                end
            end
            locked_nxt  = bus.lock;
            lock_id_nxt = sel;
        end else if (!bus.stall) begin
            locked_nxt = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr     <= '0;
            cnt     <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
        end else begin
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            locked  <= locked_nxt;
            lock_id <= lock_id_nxt;
        end
    end
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - self-checking bench for wrr_arbiter
module tb_wrr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    wrr_arbiter_if #(.CLIENTS(N), .WEIGHT_W(WW)) bus();

    wrr_arbiter #(.CLIENTS(N), .WEIGHT_W(WW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int m_ptr, m_cnt, m_locked, m_lock_id;

    task automatic drive(input logic rst, input logic [N-1:0] req, input logic lk,
                         input logic st, input logic [N*WW-1:0] w);
        @(negedge clock);
        reset       = rst;
        bus.request = req;
        bus.lock    = lk;
        bus.stall   = st;
        bus.weight  = w;
        #1;
    endtask

    task automatic do_reset();
        repeat (2) drive(1'b1, '0, 1'b0, 1'b0, 16'h1111);
    endtask

    // Reference model: state is held as plain integers and advanced straight from the arbitration rules.
    function automatic int model_sel(input logic rst, input logic [N-1:0] req, input logic st);
        if (rst || st || req == '0) return -1;
        if (m_locked != 0 && req[m_lock_id]) return m_lock_id;
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input logic rst, input logic [N-1:0] req, input logic st,
                                input logic lk, input logic [N*WW-1:0] w);
        int c, used, ew;
        bit from_lock;
        c = model_sel(rst, req, st);
        from_lock = (m_locked != 0) && req[m_lock_id];
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_locked = 0; m_lock_id = 0;
        end else if (c >= 0) begin
            if (!from_lock) begin
                used = (c == m_ptr) ? m_cnt + 1 : 1;
                ew   = int'(w[c*WW +: WW]);
                if (ew == 0) ew = 1;
                if (used >= ew) begin
                    m_ptr = (c + 1) % N;
                    m_cnt = 0;
                end else begin
                    m_ptr = c;
                    m_cnt = used;
                end
            end
            m_locked  = lk ? 1 : 0;
            m_lock_id = c;
        end else if (!st) begin
            m_locked = 0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b1111, 1'b0, 1'b0, 16'h1111);
            n_checks++;
            if (bus.grant !== 4'b0000 || bus.grant_valid !== 1'b0 || bus.grant_id !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_grant: got %b/%b/%0d expected 0000/0/0", bus.grant, bus.grant_valid, bus.grant_id);
            end
        end
        drive(1'b0, 4'b1111, 1'b0, 1'b0, 16'h1111);
        n_checks++;
        if (bus.grant !== 4'b0001 || bus.grant_valid !== 1'b1 || bus.grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL first_after_reset: got %b/%b/%0d expected 0001/1/0", bus.grant, bus.grant_valid, bus.grant_id);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'b1111, 1'b0, 1'b0, 16'h1111);
            n_checks++;
            if (bus.grant !== exp[i]) begin
                n_fail++;
                $display("FAIL round_robin[%0d]: got %b expected %b", i, bus.grant, exp[i]);
            end
        end
    endtask

    task automatic test_weights();
        logic [3:0] exp [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'b0111, 1'b0, 1'b0, 16'h1013);
            n_checks++;
            if (bus.grant !== exp[i]) begin
                n_fail++;
                $display("FAIL weights[%0d]: got %b expected %b", i, bus.grant, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic       st  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] exp [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 4'b0011, 1'b0, st[i], 16'h1113);
            n_checks++;
            if (bus.grant !== exp[i] || bus.grant_valid !== (exp[i] != 4'b0000)) begin
                n_fail++;
                $display("FAIL stall[%0d]: got %b/%b expected %b", i, bus.grant, bus.grant_valid, exp[i]);
            end
        end
    endtask

    task automatic test_lock();
        logic       lk  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 4'b1111, lk[i], 1'b0, 16'h1111);
            n_checks++;
            if (bus.grant !== exp[i]) begin
                n_fail++;
                $display("FAIL lock[%0d]: got %b expected %b", i, bus.grant, exp[i]);
            end
        end
    endtask

    task automatic test_lock_drop();
        logic       lk  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [3:0] req [5] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1011};
        logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, req[i], lk[i], 1'b0, 16'h1111);
            n_checks++;
            if (bus.grant !== exp[i]) begin
                n_fail++;
                $display("FAIL lock_drop[%0d]: got %b expected %b", i, bus.grant, exp[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  req [6] = '{4'b1111, 4'b1111, 4'b1111, 4'b1001, 4'b1001, 4'b1001};
        logic [3:0]  exp [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, req[i], 1'b0, 1'b0, 16'h2111);
            n_checks++;
            if (bus.grant !== exp[i] || bus.grant_id !== 2'(exp[i] == 4'b1000 ? 3 : exp[i] == 4'b0100 ? 2 : exp[i] == 4'b0010 ? 1 : 0)) begin
                n_fail++;
                $display("FAIL wrap[%0d]: got %b id %0d expected %b", i, bus.grant, bus.grant_id, exp[i]);
            end
        end
    endtask

    task automatic test_weight_change();
        logic [3:0]  req [7] = '{4'b1111, 4'b1111, 4'b1111, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
        logic [15:0] w   [7] = '{16'h2111, 16'h2111, 16'h2111, 16'h2111, 16'h1111, 16'h1111, 16'h1111};
        logic [3:0]  exp [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b1000};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, req[i], 1'b0, 1'b0, w[i]);
            n_checks++;
            if (bus.grant !== exp[i]) begin
                n_fail++;
                $display("FAIL weight_change[%0d]: got %b expected %b", i, bus.grant, exp[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0]    req;
        logic [N*WW-1:0] w;
        logic            st, lk, rst;
        logic [N-1:0]    exp_grant;
        int              c;
        do_reset();
        m_ptr = 0; m_cnt = 0; m_locked = 0; m_lock_id = 0;
        w = 16'h1111;
        for (int i = 0; i < 800; i++) begin
            if (i % 16 == 0) w = 16'($urandom);
            req = N'($urandom);
            st  = ($urandom_range(0, 9) == 0);
            lk  = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 99) == 0);
            drive(rst, req, lk, st, w);
            c = model_sel(rst, req, st);
            exp_grant = (c < 0) ? '0 : N'(1) << c;
            n_checks++;
            if (bus.grant !== exp_grant || bus.grant_valid !== (c >= 0)
                || bus.grant_id !== ((c < 0) ? 2'd0 : 2'(c))) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b/%b/%0d expected %b/%0d (req %b st %b lk %b rst %b)",
                         i, bus.grant, bus.grant_valid, bus.grant_id, exp_grant, c, req, st, lk, rst);
            end
            n_checks++;
            if (!$onehot0(bus.grant) || (bus.grant & ~req) != '0
                || ((|req) && !st && !rst && !$onehot(bus.grant))) begin
                n_fail++;
                $display("FAIL invariant[%0d]: got grant %b with request %b stall %b", i, bus.grant, req, st);
            end
            model_update(rst, req, st, lk, w);
        end
    endtask

    initial begin
        bus.request = '0;
        bus.weight  = 16'h1111;
        bus.stall   = 1'b0;
        bus.lock    = 1'b0;
        test_reset();
        test_round_robin();
        test_weights();
        test_stall();
        test_lock();
        test_lock_drop();
        test_wrap();
        test_weight_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- Weighted round-robin arbiter for CLIENTS requesters. It is the parametrised successor to the plain round-robin arbiter.
- Each client gets up to weight[i] consecutive grants before priority rotates past it.
- Adds stall and a burst lock.
- Sits between request sources and a shared resource; grants are combinational from the current arbitration state.

Parameters:
- CLIENTS, 32, number of requesters; must be >= 2; need not be a power of two.
- WEIGHT_W, 4, width of each per-client weight field and of the internal credit counter.
- IDX_W, $clog2(CLIENTS), width of grant_id (derived; not overridden).

Ports:
- clock  input  1  clock; all state updates on posedge.
- reset  input  1  reset, synchronous, active-high.
- request  input  CLIENTS  per-client request; held by the source until granted.
- weight  input  CLIENTS*WEIGHT_W  client i weight in bits [i*WEIGHT_W +: WEIGHT_W]; 0 is treated as 1.
- stall  input  1  suppresses all grants and freezes state this cycle.
- lock  input  1  keeps the current grantee for the next cycle without consuming credit.
- grant  output  CLIENTS  one-hot or zero grant vector.
- grant_valid  output  1  equals |grant.
- grant_id  output  IDX_W  index of the granted client; 0 when grant_valid=0.

Behaviour:
- State:
  - ptr (IDX_W): highest-priority client.
  - cnt (WEIGHT_W): grants already consumed by client ptr in its current turn.
  - locked (1) and lock_id (IDX_W).
- Reset: ptr=0, cnt=0, locked=0, lock_id=0. While reset=1, grant=0, grant_valid=0, grant_id=0 regardless of request.
- Effective weight: ew(i) = (weight[i]==0) ? 1 : weight[i], sampled in the grant cycle.
- Grant selection (combinational, zero latency):
  - If stall=1 or request==0: grant=0.
  - Else if locked=1 and request[lock_id]=1: grant client lock_id.
  - Else: grant the first client c with request[c]=1, searching circularly from ptr (inclusive) upward, wrapping CLIENTS-1 -> 0.
- State update at a posedge with reset=0, only when a grant was issued:
  - Lock path (grant came from locked=1): ptr and cnt unchanged.
  - Otherwise:
    - used = (c==ptr) ? cnt+1 : 1.
    - If used >= ew(c): ptr = (c+1) mod CLIENTS, cnt = 0.
    - Else: ptr = c, cnt = used.
  - On every grant: locked = lock, lock_id = c.
- No-grant cycles:
  - stall=1: all state held, including locked and lock_id.
  - request==0 and stall=0: ptr and cnt held; locked cleared.
- Lock boundaries:
  - Locked client deasserts request: lock is void. Normal search from ptr that cycle; locked updated from that cycle's lock input.
  - lock=1 with no grant: ignored.
- Credit boundaries:
  - Owner at ptr drops request mid-turn: the search skips it. The next grantee c != ptr restarts credit at used=1; the old client's remaining credit is lost.
  - ptr=CLIENTS-1 exhausting its credit wraps ptr to 0.
  - cnt never exceeds ew-1; no overflow, since the maximum weight is 2^WEIGHT_W-1.
- Weight change mid-turn: the new ew applies at the next grant. If cnt+1 >= new ew, the turn ends immediately on that grant.
- Invariants (asserted by the bench):
  - $onehot0(grant).
  - grant ⊆ request.
  - (|request && !stall && !reset) |-> $onehot(grant).
  - grant_id consistent with grant.
  - No starvation: a held request is granted within CLIENTS*(2^WEIGHT_W-1) non-stall, non-lock grant cycles.
  - With all weights equal to 1 and lock=0, behaviour is identical to a plain round-robin arbiter.

Test Plan:
- Reset, CLIENTS=4, request=4'b1111 held through 2 reset cycles:
  - -> grant=0000 during reset.
  - -> first cycle after reset grant=0001, grant_id=0.
- All weights 1, request=1111 held, lock=0:
  - -> grant sequence 0001,0010,0100,1000,0001 (wrap).
- Weights w0=3, w1=1, w2=0 (treated as 1), request=0111 held:
  - -> 0001,0001,0001,0010,0100,0001,0001,0001.
- w0=3, request=0011:
  - -> grant 0001.
  - -> then stall=1 for 2 cycles -> grant=0000, state held.
  - -> then 0001,0001,0010.
- All weights 1, request=1111:
  - -> grant 0100 with lock=1 for 3 consecutive grant cycles -> 0100 x4, then 1000.
  - -> repeat with request[2] dropped after the 2nd grant -> next grant 1000.
- w3=2, ptr at 3, request=1001:
  - -> 1000,1000,0001 (ptr wraps to 0).
  - -> w3 changed 2->1 after the first 1000 grant -> 1000 then 0001.
